alu_md_unit: RTL



---
 rtl/alu_md_pkg.sv | 68 ++++++
 rtl/alu_md_iter.sv | 108 ++++++++++
 rtl/alu_md_unit.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_md_pkg.sv
// alu_md_pkg: opcodes, FSM states and helpers shared by the ALU/MD unit.
// Optional feature macro: ALU_MD_MACC_EN (MADD/MADDU/MSUB/MSUBU).
package alu_md_pkg;

   localparam int MAXW = 128;

   localparam logic [5:0] OP_AND   = 6'd0;
   localparam logic [5:0] OP_OR    = 6'd1;
   localparam logic [5:0] OP_XOR   = 6'd2;
   localparam logic [5:0] OP_NOR   = 6'd3;
   localparam logic [5:0] OP_ADD   = 6'd4;
   localparam logic [5:0] OP_ADDU  = 6'd5;
   localparam logic [5:0] OP_SUB   = 6'd6;
   localparam logic [5:0] OP_SUBU  = 6'd7;
   localparam logic [5:0] OP_SLT   = 6'd8;
   localparam logic [5:0] OP_SLTU  = 6'd9;
   localparam logic [5:0] OP_SLL   = 6'd10;
   localparam logic [5:0] OP_SRL   = 6'd11;
   localparam logic [5:0] OP_SRA   = 6'd12;
   localparam logic [5:0] OP_SLLV  = 6'd13;
   localparam logic [5:0] OP_SRLV  = 6'd14;
   localparam logic [5:0] OP_SRAV  = 6'd15;
   localparam logic [5:0] OP_LUI   = 6'd16;
   localparam logic [5:0] OP_CLO   = 6'd17;
   localparam logic [5:0] OP_CLZ   = 6'd18;
   localparam logic [5:0] OP_MOVN  = 6'd19;
   localparam logic [5:0] OP_MOVZ  = 6'd20;
   localparam logic [5:0] OP_MFHI  = 6'd21;
   localparam logic [5:0] OP_MFLO  = 6'd22;
   localparam logic [5:0] OP_MTHI  = 6'd23;
   localparam logic [5:0] OP_MTLO  = 6'd24;
   localparam logic [5:0] OP_MULT  = 6'd25;
   localparam logic [5:0] OP_MULTU = 6'd26;
   localparam logic [5:0] OP_DIV   = 6'd27;
   localparam logic [5:0] OP_DIVU  = 6'd28;
   localparam logic [5:0] OP_MADD  = 6'd29;
   localparam logic [5:0] OP_MADDU = 6'd30;
   localparam logic [5:0] OP_MSUB  = 6'd31;
   localparam logic [5:0] OP_MSUBU = 6'd32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef enum logic {
      MK_MUL = 1'b0,
      MK_DIV = 1'b1
   } md_kind_e;

   // Leading zeros within the low w bits of v (w when v is zero there).
   function automatic int lead_zeros(input logic [MAXW-1:0] v,
                                     input int w);
      int   n;
      logic stop;
      n    = 0;
      stop = 1'b0;
      for (int i = MAXW - 1; i >= 0; i--) begin
         if (i < w && !stop) begin
            if (v[i]) stop = 1'b1;
            else      n    = n + 1;
         end
      end
      return n;
   endfunction

endpackage

// File: rtl/alu_md_iter.sv
// alu_md_iter: radix-2 shift-add multiplier / restoring divider.
// Runs WIDTH iterations on magnitudes, then applies the sign fix-up.
module alu_md_iter
   import alu_md_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             i_start,
   input  logic             i_signed,
   input  md_kind_e         i_kind,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_done,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);

   logic             r_busy;
   logic [SHW-1:0]   r_cnt;
   md_kind_e         r_kind;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_a;
   logic             r_neg;
   logic             r_rneg;
   logic             r_dz;

   logic [WIDTH-1:0]   w_ma;
   logic [WIDTH-1:0]   w_mb;
   logic [WIDTH:0]     w_sum;
   logic [WIDTH:0]     w_rs;
   logic [WIDTH-1:0]   w_sub;
   logic               w_ge;
   logic [WIDTH-1:0]   w_nhi;
   logic [WIDTH-1:0]   w_nlo;
   logic [2*WIDTH-1:0] w_prod;

   // Operand magnitudes for the signed variants.
   always_comb begin
      w_ma = (i_signed && i_a[WIDTH-1]) ? -i_a : i_a;
      w_mb = (i_signed && i_b[WIDTH-1]) ? -i_b : i_b;
   end

   // One iteration step applied to the current partial state.
   always_comb begin
      w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
      w_rs  = {r_hi, r_lo[WIDTH-1]};
      w_ge  = w_rs >= {1'b0, r_b};
      w_sub = w_rs[WIDTH-1:0] - r_b;
      if (r_kind == MK_DIV) begin
         w_nhi = w_ge ? w_sub : w_rs[WIDTH-1:0];
         w_nlo = {r_lo[WIDTH-2:0], w_ge};
      end else begin
         w_nhi = w_sum[WIDTH:1];
         w_nlo = {w_sum[0], r_lo[WIDTH-1:1]};
      end
   end

   // Sign fix-up of the final step; divide-by-zero overrides.
   always_comb begin
      w_prod = r_neg ? -{w_nhi, w_nlo} : {w_nhi, w_nlo};
      o_done = r_busy && (r_cnt == SHW'(WIDTH - 1));
      if (r_kind == MK_DIV) begin
         o_lo = r_dz ? '1 : (r_neg ? -w_nlo : w_nlo);
         o_hi = r_dz ? r_a : (r_rneg ? -w_nhi : w_nhi);
      end else begin
         o_hi = w_prod[2*WIDTH-1:WIDTH];
         o_lo = w_prod[WIDTH-1:0];
      end
   end

   // Load on start, then iterate once per cycle until done.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_busy <= 1'b0;
         r_cnt  <= '0;
         r_kind <= MK_MUL;
         r_hi   <= '0;
         r_lo   <= '0;
         r_b    <= '0;
         r_a    <= '0;
         r_neg  <= 1'b0;
         r_rneg <= 1'b0;
         r_dz   <= 1'b0;
      end else if (i_start) begin
         r_busy <= 1'b1;
         r_cnt  <= '0;
         r_kind <= i_kind;
         r_hi   <= '0;
         r_lo   <= w_ma;
         r_b    <= w_mb;
         r_a    <= i_a;
         r_neg  <= i_signed && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
         r_rneg <= i_signed && i_a[WIDTH-1];
         r_dz   <= (i_b == '0);
      end else if (r_busy) begin
         r_hi  <= w_nhi;
         r_lo  <= w_nlo;
         r_cnt <= r_cnt + SHW'(1);
         if (o_done) r_busy <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_md_unit.sv
// alu_md_unit: registered ALU with handshake plus iterative mul/div, HI/LO.
// Optional feature macro: ALU_MD_MACC_EN (multiply-accumulate ops).
module alu_md_unit
   import alu_md_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             InValid,
   output logic             InReady,
   input  logic [5:0]       Op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [SHW-1:0]   ShiftAmount,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [WIDTH-1:0] Result,
   output logic             Zero,
   output logic             OverFlow,
   output logic             WriteEnable,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo
);

   state_e           r_state;
   state_e           w_next;
   logic [WIDTH-1:0] r_res;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic             r_of;
   logic             r_we;
   logic             r_zero;

   logic             w_take;
   logic             w_md;
   logic             w_sgn;
   md_kind_e         w_kind;
   logic             w_fin;
   logic             w_it_done;
   logic [WIDTH-1:0] w_it_hi;
   logic [WIDTH-1:0] w_it_lo;
   logic [WIDTH-1:0] w_res;
   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] w_dif;
   logic             w_of;
   logic             w_we;

`ifdef ALU_MD_MACC_EN
   logic               w_macc;
   logic               r_macc;
   logic               r_msub;
   logic               r_acc_ph;
   logic [2*WIDTH-1:0] r_prod;
   logic [2*WIDTH-1:0] w_acc_hl;
`endif

   assign w_take = InValid && InReady;

   // Classify the offered op: multi-cycle, signedness, engine kind.
   always_comb begin
      w_md   = 1'b0;
      w_sgn  = 1'b0;
      w_kind = MK_MUL;
`ifdef ALU_MD_MACC_EN
      w_macc = 1'b0;
`endif
      unique case (Op)
         OP_MULT:  begin w_md = 1'b1; w_sgn = 1'b1; end
         OP_MULTU: w_md = 1'b1;
         OP_DIV:   begin w_md = 1'b1; w_sgn = 1'b1; w_kind = MK_DIV; end
         OP_DIVU:  begin w_md = 1'b1; w_kind = MK_DIV; end
`ifdef ALU_MD_MACC_EN
         OP_MADD, OP_MSUB: begin
            w_md = 1'b1; w_sgn = 1'b1; w_macc = 1'b1;
         end
         OP_MADDU, OP_MSUBU: begin
            w_md = 1'b1; w_macc = 1'b1;
         end
`endif
         default: w_md = 1'b0;
      endcase
   end

   alu_md_iter #(
      .WIDTH (WIDTH),
      .SHW   (SHW)
   ) u_iter (
      .Clk      (Clk),
      .Rst_n    (Rst_n),
      .i_start  (w_take && w_md),
      .i_signed (w_sgn),
      .i_kind   (w_kind),
      .i_a      (A),
      .i_b      (B),
      .o_done   (w_it_done),
      .o_hi     (w_it_hi),
      .o_lo     (w_it_lo)
   );

`ifdef ALU_MD_MACC_EN
   assign w_fin    = (w_it_done && !r_macc) || r_acc_ph;
   assign w_acc_hl = r_msub ? ({r_hi, r_lo} - r_prod)
                            : ({r_hi, r_lo} + r_prod);
`else
   assign w_fin = w_it_done;
`endif

   // Single-cycle datapath evaluated on the offered operands.
   always_comb begin
      w_sum = A + B;
      w_dif = A - B;
      w_res = '0;
      w_of  = 1'b0;
      w_we  = 1'b1;
      unique case (Op)
         OP_AND:  w_res = A & B;
         OP_OR:   w_res = A | B;
         OP_XOR:  w_res = A ^ B;
         OP_NOR:  w_res = ~(A | B);
         OP_ADD: begin
            w_res = w_sum;
            w_of  = (A[WIDTH-1] == B[WIDTH-1]) &&
                    (w_sum[WIDTH-1] != A[WIDTH-1]);
            w_we  = !w_of;
         end
         OP_ADDU: w_res = w_sum;
         OP_SUB: begin
            w_res = w_dif;
            w_of  = (A[WIDTH-1] != B[WIDTH-1]) &&
                    (w_dif[WIDTH-1] != A[WIDTH-1]);
            w_we  = !w_of;
         end
         OP_SUBU: w_res = w_dif;
         OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
         OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, A < B};
         OP_SLL:  w_res = B << ShiftAmount;
         OP_SRL:  w_res = B >> ShiftAmount;
         OP_SRA:  w_res = $signed(B) >>> ShiftAmount;
         OP_SLLV: w_res = B << A[SHW-1:0];
         OP_SRLV: w_res = B >> A[SHW-1:0];
         OP_SRAV: w_res = $signed(B) >>> A[SHW-1:0];
         OP_LUI:  w_res = B << (WIDTH / 2);
         OP_CLO:  w_res = WIDTH'(lead_zeros(MAXW'(~A), WIDTH));
         OP_CLZ:  w_res = WIDTH'(lead_zeros(MAXW'(A), WIDTH));
         OP_MOVN: begin
            if (B != '0) w_res = A;
            else         w_we  = 1'b0;
         end
         OP_MOVZ: begin
            if (B == '0) w_res = A;
            else         w_we  = 1'b0;
         end
         OP_MFHI: w_res = r_hi;
         OP_MFLO: w_res = r_lo;
         OP_MTHI, OP_MTLO: w_we = 1'b0;
         default: begin
            w_res = '1;
            w_we  = 1'b0;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // FSM next-state logic.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE: if (w_take) w_next = w_md ? BUSY : DONE;
         BUSY: if (w_fin)  w_next = DONE;
         DONE: begin
            if (w_take)        w_next = w_md ? BUSY : DONE;
            else if (OutReady) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // FSM outputs: handshake flags.
   always_comb begin
      InReady  = 1'b0;
      OutValid = 1'b0;
      unique case (r_state)
         IDLE: InReady = 1'b1;
         DONE: begin
            InReady  = OutReady;
            OutValid = 1'b1;
         end
         default: InReady = 1'b0;
      endcase
   end

   // Result register and architectural HI/LO.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_res  <= '0;
         r_zero <= 1'b0;
         r_of   <= 1'b0;
         r_we   <= 1'b0;
         r_hi   <= '0;
         r_lo   <= '0;
`ifdef ALU_MD_MACC_EN
         r_macc   <= 1'b0;
         r_msub   <= 1'b0;
         r_acc_ph <= 1'b0;
         r_prod   <= '0;
`endif
      end else begin
         if (w_take && !w_md) begin
            r_res  <= w_res;
            r_zero <= (w_res == '0);
            r_of   <= w_of;
            r_we   <= w_we;
            if (Op == OP_MTHI) r_hi <= A;
            if (Op == OP_MTLO) r_lo <= A;
         end
`ifdef ALU_MD_MACC_EN
         if (w_take && w_md) begin
            r_macc <= w_macc;
            r_msub <= (Op == OP_MSUB) || (Op == OP_MSUBU);
         end
         if (w_it_done && r_macc) begin
            r_prod   <= {w_it_hi, w_it_lo};
            r_acc_ph <= 1'b1;
         end else if (w_it_done) begin
            r_hi   <= w_it_hi;
            r_lo   <= w_it_lo;
            r_res  <= w_it_lo;
            r_zero <= (w_it_lo == '0);
            r_of   <= 1'b0;
            r_we   <= 1'b0;
         end
         if (r_acc_ph) begin
            r_acc_ph <= 1'b0;
            r_hi     <= w_acc_hl[2*WIDTH-1:WIDTH];
            r_lo     <= w_acc_hl[WIDTH-1:0];
            r_res    <= w_acc_hl[WIDTH-1:0];
            r_zero   <= (w_acc_hl[WIDTH-1:0] == '0);
            r_of     <= 1'b0;
            r_we     <= 1'b0;
         end
`else
         if (w_it_done) begin
            r_hi   <= w_it_hi;
            r_lo   <= w_it_lo;
            r_res  <= w_it_lo;
            r_zero <= (w_it_lo == '0);
            r_of   <= 1'b0;
            r_we   <= 1'b0;
         end
`endif
      end
   end

   assign Result      = r_res;
   assign Zero        = r_zero;
   assign OverFlow    = r_of;
   assign WriteEnable = r_we;
   assign Hi          = r_hi;
   assign Lo          = r_lo;

endmodule
